cae_window_feeder: RTL

Streaming sliding-window generator directly upstream of the convolution array. It accepts one pixel per cycle in raster order, holds the previous `INPUT_SIZE-1` image rows in line buffers, and presents each complete `INPUT_SIZE`×`INPUT_SIZE` window as three row vectors. Those vectors drive the array's `data_row1_in`/`data_row2_in`/`data_row3_in` inputs, with a valid/ready handshake toward the array's controller.

---
 rtl/cae_window_feeder_pkg.sv | 9 +
 rtl/cae_window_feeder_if.sv | 30 +++
 rtl/cae_window_feeder_line_buffer.sv | 23 ++
 rtl/cae_window_feeder.sv | 110 +++++++++++
 4 files changed

// File: rtl/cae_window_feeder_pkg.sv
// Shared defaults for the sliding-window feeder that sits in front of the convolution array.
package cae_window_feeder_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_INPUT_SIZE = 3;
   localparam int DEF_IMG_WIDTH  = 28;
   localparam int DEF_IMG_HEIGHT = 28;

endpackage

// File: rtl/cae_window_feeder_if.sv
// Pixel-in / window-out handshake bundle; master drives pixels and consumes windows.
interface cae_window_feeder_if
   import cae_window_feeder_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int INPUT_SIZE = DEF_INPUT_SIZE
) ();

   logic                                  enable;
   logic [DATA_WIDTH-1:0]                 pix_in;
   logic                                  pix_valid;
   logic                                  pix_ready;
   logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0] data_row1_out;
   logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0] data_row2_out;
   logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0] data_row3_out;
   logic                                  win_valid;
   logic                                  win_ready;
   logic                                  frame_done;

   modport master (
      output enable, pix_in, pix_valid, win_ready,
      input  pix_ready, data_row1_out, data_row2_out, data_row3_out, win_valid, frame_done
   );

   modport slave (
      input  enable, pix_in, pix_valid, win_ready,
      output pix_ready, data_row1_out, data_row2_out, data_row3_out, win_valid, frame_done
   );

endinterface

// File: rtl/cae_window_feeder_line_buffer.sv
// One image row of storage: asynchronous read, synchronous write at the same address.
module cae_window_feeder_line_buffer #(
   parameter int DEPTH      = 28,
   parameter int DATA_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   output logic [DATA_WIDTH-1:0]    rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/cae_window_feeder.sv
// Raster-order pixel stream to 3x3 sliding windows, one window per accepted pixel once two rows are buffered.
module cae_window_feeder
   import cae_window_feeder_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int INPUT_SIZE = DEF_INPUT_SIZE,
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
   input logic               clk,
   input logic               rst,
   cae_window_feeder_if.slave bus
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] WIN_COL0  = CW'(INPUT_SIZE - 1);
   localparam logic [RW-1:0] WIN_ROW0  = RW'(INPUT_SIZE - 1);

   typedef logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0] win_row_t;

   logic [CW-1:0]         col_reg, col_next;
   logic [RW-1:0]         row_reg, row_next;
   win_row_t              row1_reg, row1_next, row2_reg, row2_next, row3_reg, row3_next;
   win_row_t              shift1, shift2, shift3;
   logic                  win_valid_reg, win_valid_next;
   logic                  frame_done_reg, frame_done_next;
   logic [DATA_WIDTH-1:0] old_rd, mid_rd;
   logic                  pix_ready, accept, complete, col_wrap, frame_end;

   assign pix_ready = rst && bus.enable && (!win_valid_reg || bus.win_ready);
   assign accept    = bus.pix_valid && pix_ready;
   assign complete  = (row_reg >= WIN_ROW0) && (col_reg >= WIN_COL0);
   assign col_wrap  = (col_reg == COL_LAST);
   assign frame_end = col_wrap && (row_reg == ROW_LAST);

   // Rows age through the buffers: mid holds row r-1, old holds row r-2.
   cae_window_feeder_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) lb_old (
      .clk(clk), .we(accept), .addr(col_reg), .wdata(mid_rd), .rdata(old_rd)
   );

   cae_window_feeder_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) lb_mid (
      .clk(clk), .we(accept), .addr(col_reg), .wdata(bus.pix_in), .rdata(mid_rd)
   );

   genvar gi;
   for (gi = 0; gi < INPUT_SIZE - 1; gi++) begin : g_shift
      assign shift1[gi] = row1_reg[gi+1];
      assign shift2[gi] = row2_reg[gi+1];
      assign shift3[gi] = row3_reg[gi+1];
   end
   assign shift1[INPUT_SIZE-1] = old_rd;
   assign shift2[INPUT_SIZE-1] = mid_rd;
   assign shift3[INPUT_SIZE-1] = bus.pix_in;

   always_comb begin
      col_next        = col_reg;
      row_next        = row_reg;
      row1_next       = row1_reg;
      row2_next       = row2_reg;
      row3_next       = row3_reg;
      win_valid_next  = win_valid_reg;
      frame_done_next = accept && frame_end;
      if (accept) begin
         col_next  = col_wrap ? '0 : col_reg + CW'(1);
         if (col_wrap) begin
            row_next = (row_reg == ROW_LAST) ? '0 : row_reg + RW'(1);
         end
         row1_next = shift1;
         row2_next = shift2;
         row3_next = shift3;
      end
      // A completing accept in the same cycle as a take keeps the window stream unbroken.
      if (accept && complete) begin
         win_valid_next = 1'b1;
      end else if (bus.win_ready) begin
         win_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         col_reg        <= '0;
         row_reg        <= '0;
         row1_reg       <= '0;
         row2_reg       <= '0;
         row3_reg       <= '0;
         win_valid_reg  <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         col_reg        <= col_next;
         row_reg        <= row_next;
         row1_reg       <= row1_next;
         row2_reg       <= row2_next;
         row3_reg       <= row3_next;
         win_valid_reg  <= win_valid_next;
         frame_done_reg <= frame_done_next;
      end
   end

   assign bus.pix_ready     = pix_ready;
   assign bus.data_row1_out = row1_reg;
   assign bus.data_row2_out = row2_reg;
   assign bus.data_row3_out = row3_reg;
   assign bus.win_valid     = win_valid_reg;
   assign bus.frame_done    = frame_done_reg;

endmodule
